// File: rtl/mci_cif_sram_resp.sv
// cif_if target that fronts a single-port word SRAM with RD_LATENCY-cycle reads.
// Accesses are classified in IDLE. Errors and writes complete in the same cycle, and reads stall on cif_hold.
module mci_cif_sram_resp #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int USER_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cif_dv,
    input  logic [ADDR_WIDTH-1:0]          cif_addr,
    input  logic                           cif_write,
    input  logic [DATA_WIDTH-1:0]          cif_wdata,
    input  logic [DATA_WIDTH/8-1:0]        cif_wstrb,
    input  logic [USER_WIDTH-1:0]          cif_user,
    output logic                           cif_hold,
    output logic [DATA_WIDTH-1:0]          cif_rdata,
    output logic                           cif_error,
    input  logic                           wr_lock,
    input  logic [USER_WIDTH-1:0]          lock_user,
    output logic                           sram_cs,
    output logic                           sram_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]          sram_wdata,
    output logic [DATA_WIDTH/8-1:0]        sram_wbe,
    input  logic [DATA_WIDTH-1:0]          sram_rdata,
    output logic [7:0]                     err_cnt
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int SAW   = $clog2(DEPTH_WORDS);

    localparam logic [ADDR_WIDTH:0]   REGION_BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS * BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK   = ADDR_WIDTH'(BYTES - 1);
    localparam logic [1:0]            LAT_M1       = 2'(RD_LATENCY - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_check
        $error("mci_cif_sram_resp: RD_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DATA
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [SAW-1:0]   addr_q, addr_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             req_bad;
    logic             req_lock;
    logic [SAW-1:0]   req_word;

    assign req_bad  = ((cif_addr & ALIGN_MASK) != '0) || ({1'b0, cif_addr} >= REGION_BYTES);
    assign req_lock = cif_write && wr_lock && (cif_user != lock_user);
    assign req_word = cif_addr[OFF +: SAW];

    // NOTE: every output and *_d gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        err_cnt_d  = err_cnt_q;
        cif_hold   = 1'b0;
        cif_error  = 1'b0;
        cif_rdata  = '0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = addr_q;
        sram_wdata = cif_wdata;
        sram_wbe   = '0;

        unique case (state_q)
            IDLE: begin
                sram_addr = req_word;
                if (cif_dv) begin
                    if (req_bad || req_lock) begin
                        cif_error = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end else if (cif_write) begin
                        sram_cs  = 1'b1;
                        sram_we  = 1'b1;
                        sram_wbe = cif_wstrb;
                    end else begin
                        sram_cs  = 1'b1;
                        cif_hold = 1'b1;
                        addr_d   = req_word;
                        cnt_d    = LAT_M1;
                        state_d  = (RD_LATENCY > 1) ? RD_WAIT : RD_DATA;
                    end
                end
            end
            RD_WAIT: begin
                cif_hold = 1'b1;
                cnt_d    = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = RD_DATA;
            end
            RD_DATA: begin
                cif_rdata = sram_rdata;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Keep the SRAM quiet and the cif outputs at their reset values while rst is held.
        if (rst) begin
            cif_hold  = 1'b0;
            cif_error = 1'b0;
            cif_rdata = '0;
            sram_cs   = 1'b0;
            sram_we   = 1'b0;
            sram_wbe  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

    a_cs_only_idle : assert property (@(posedge clk) disable iff (rst)
        sram_cs |-> (state_q == IDLE));

    a_no_idle_hold : assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE && !cif_dv) |-> !cif_hold);

    a_req_stable : assert property (@(posedge clk) disable iff (rst)
        (cif_dv && cif_hold) |=> (cif_dv && $stable(cif_addr) && $stable(cif_write) &&
                                  $stable(cif_wdata) && $stable(cif_wstrb) && $stable(cif_user)));

endmodule

// File: tb/tb_mci_cif_sram_resp.sv
// Scoreboard bench for mci_cif_sram_resp: byte-level reference model, SRAM model and completion monitor.
module tb_mci_cif_sram_resp;

    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int UW     = 32;
    localparam int DEPTH  = 1024;
    localparam int LAT    = 2;
    localparam int REGION = DEPTH * (DW / 8);

    logic          clk;
    logic          rst;
    logic          cif_dv;
    logic [AW-1:0] cif_addr;
    logic          cif_write;
    logic [DW-1:0] cif_wdata;
    logic [3:0]    cif_wstrb;
    logic [UW-1:0] cif_user;
    logic          cif_hold;
    logic [DW-1:0] cif_rdata;
    logic          cif_error;
    logic          wr_lock;
    logic [UW-1:0] lock_user;
    logic          sram_cs;
    logic          sram_we;
    logic [9:0]    sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [3:0]    sram_wbe;
    logic [DW-1:0] sram_rdata;
    logic [7:0]    err_cnt;

    mci_cif_sram_resp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .USER_WIDTH (UW),
        .DEPTH_WORDS(DEPTH),
        .RD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cif_dv    (cif_dv),
        .cif_addr  (cif_addr),
        .cif_write (cif_write),
        .cif_wdata (cif_wdata),
        .cif_wstrb (cif_wstrb),
        .cif_user  (cif_user),
        .cif_hold  (cif_hold),
        .cif_rdata (cif_rdata),
        .cif_error (cif_error),
        .wr_lock   (wr_lock),
        .lock_user (lock_user),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_wbe  (sram_wbe),
        .sram_rdata(sram_rdata),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: byte-enabled writes, reads appear LAT cycles after cs & ~we.
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] rd_pipe  [LAT];

    always @(posedge clk) begin
        if (sram_cs && sram_we) begin
            for (int b = 0; b < 4; b++)
                if (sram_wbe[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        rd_pipe[0] <= (sram_cs && !sram_we) ? sram_mem[sram_addr] : DW'($urandom);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[LAT-1];

    // Reference model: the region as a flat byte array plus an error counter.
    logic [7:0] ref_bytes [REGION];
    int         ref_err;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          error;
    } sb_t;
    sb_t sb_q[$];

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] user,
                         output sb_t e, output logic exp_cs, output int exp_cycles);
        logic bad, locked;
        bad    = (addr % 4 != 0) || (addr >= REGION);
        locked = wr && wr_lock && (user != lock_user);
        e.rdata    = '0;
        e.error    = 1'b0;
        exp_cs     = 1'b0;
        exp_cycles = 1;
        if (bad || locked) begin
            e.error = 1'b1;
            if (ref_err < 255) ref_err++;
        end else if (wr) begin
            exp_cs = 1'b1;
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_bytes[addr + b] = wdata[8*b +: 8];
        end else begin
            exp_cs     = 1'b1;
            exp_cycles = LAT + 1;
            e.rdata    = {ref_bytes[addr + 3], ref_bytes[addr + 2],
                          ref_bytes[addr + 1], ref_bytes[addr]};
        end
    endtask

    // Drives one request from posedge+1 and returns at posedge+1 after its completion edge.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] user);
        sb_t  e;
        logic exp_cs;
        int   exp_cycles;
        int   n;
        bit   done;
        model(wr, addr, wdata, strb, user, e, exp_cs, exp_cycles);
        sb_q.push_back(e);
        cif_dv    = 1'b1;
        cif_write = wr;
        cif_addr  = addr;
        cif_wdata = wdata;
        cif_wstrb = strb;
        cif_user  = user;
        n    = 0;
        done = 1'b0;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("sram_cs", sram_cs, exp_cs);
                if (exp_cs) begin
                    check("sram_we", sram_we, wr);
                    check("sram_addr", sram_addr, addr[11:2]);
                    if (wr) begin
                        check("sram_wbe", sram_wbe, strb);
                        check("sram_wdata", sram_wdata, wdata);
                    end
                end
            end
            if (!cif_hold) done = 1'b1;
        end
        check("cycles_to_completion", n, exp_cycles);
        @(posedge clk);
        #1;
        cif_dv = 1'b0;
    endtask

    // Monitor: pop the scoreboard on every completion; outside completions rdata/error must be 0.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (cif_dv && !cif_hold) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    sb_t s;
                    s = sb_q.pop_front();
                    check("cif_rdata", cif_rdata, s.rdata);
                    check("cif_error", cif_error, s.error);
                end
            end else begin
                check("idle_rdata", cif_rdata, 0);
                check("idle_error", cif_error, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        logic [31:0] a;
        logic        wr;
        int          r;

        for (int i = 0; i < DEPTH; i++) sram_mem[i] = '0;
        for (int i = 0; i < REGION; i++) ref_bytes[i] = '0;
        ref_err   = 0;
        rst       = 1'b1;
        cif_dv    = 1'b0;
        cif_addr  = '0;
        cif_write = 1'b0;
        cif_wdata = '0;
        cif_wstrb = '0;
        cif_user  = '0;
        wr_lock   = 1'b0;
        lock_user = 32'h7;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold", cif_hold, 0);
        check("rst_error", cif_error, 0);
        check("rst_rdata", cif_rdata, 0);
        check("rst_cs", sram_cs, 0);
        check("rst_we", sram_we, 0);
        check("rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic write, then a latency-2 read of the same word.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h5);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'h5);

        // Back-to-back writes finish one per cycle.
        t0 = cyc;
        for (int i = 0; i < 8; i++) do_req(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 32'h5);
        check("b2b_write_cycles", cyc - t0, 8);

        // Misaligned and out-of-range reads.
        do_req(1'b0, 32'h12, 32'h0, 4'h0, 32'h5);
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'h5);
        check("err_cnt_after_bad", err_cnt, ref_err);

        // Write lock with an exempt user.
        wr_lock = 1'b1;
        do_req(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h5);
        do_req(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h7);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 32'h5);
        wr_lock = 1'b0;
        check("err_cnt_after_lock", err_cnt, ref_err);

        // Partial write and a zero-strobe write.
        do_req(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 32'h5);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'h5);
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h5);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'h5);

        // Randomised mix of reads, writes, bad addresses and locked writes.
        for (int k = 0; k < 400; k++) begin
            wr_lock = ($urandom_range(3) == 0);
            r  = $urandom_range(9);
            wr = $urandom_range(1);
            a  = 32'(4 * $urandom_range(31));
            if (r == 0) a = $urandom;
            else if (r == 1) a = a + 32'($urandom_range(3, 1));
            do_req(wr, a, $urandom, 4'($urandom), $urandom_range(1) ? 32'h7 : 32'h5);
        end
        wr_lock = 1'b0;
        check("err_cnt_after_random", err_cnt, ref_err);

        // Reset while waiting on a read: no completion, back to idle.
        cif_dv    = 1'b1;
        cif_write = 1'b0;
        cif_addr  = 32'h10;
        cif_wstrb = 4'h0;
        cif_user  = 32'h5;
        @(posedge clk);
        #1;
        check("rd_wait_hold", cif_hold, 1);
        rst    = 1'b1;
        cif_dv = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ref_err = 0;
        @(negedge clk);
        check("post_rst_hold", cif_hold, 0);
        check("post_rst_rdata", cif_rdata, 0);
        check("post_rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;

        // Counter saturation.
        for (int k = 0; k < 300; k++)
            do_req(1'b0, (k % 2) ? 32'h2 : 32'h4000, 32'h0, 4'h0, 32'h5);
        check("err_cnt_saturated", err_cnt, ref_err);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 32'h5);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
